// File: rtl/param_addsub_entry_if.sv
// Board-side bundle for the serial-entry add/sub unit: encoder strobe and
// switch chunk in, registered arithmetic result and status out.
interface param_addsub_entry_if #(
  parameter int WIDTH = 7,
  parameter int NIB   = 4
);
  logic             rotation_event;
  logic [NIB-1:0]   data_in;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             valid;
  logic [1:0]       state;

  modport master (
    output rotation_event, data_in,
    input  result, carry_out, overflow, valid, state
  );

  modport slave (
    input  rotation_event, data_in,
    output result, carry_out, overflow, valid, state
  );
endinterface

// File: rtl/param_addsub_entry.sv
// Signed add/sub unit whose operands and opcode are keyed in NIB bits per encoder step.
// Optional macro SATURATE_EN clamps overflowed results to the signed extreme.
module param_addsub_entry #(
  parameter int WIDTH = 7,
  parameter int NIB   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_addsub_entry_if.slave   bus
);

  localparam int CHUNKS = (WIDTH + NIB - 1) / NIB;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t           stateQ, stateNext;
  logic [IW-1:0]    chunkQ, chunkNext;
  logic [WIDTH-1:0] opAQ, opANext, opBQ, opBNext;
  logic [WIDTH-1:0] resultQ, resultNext;
  logic [1:0]       opQ, opNext;
  logic             carryQ, carryNext, ovfQ, ovfNext, validQ, validNext;
  logic             prevEvt, strobe, lastChunk, firstChunk;
  logic [WIDTH-1:0] chunkMask, chunkData;
  logic [WIDTH-1:0] x, y, sumRes;
  logic [WIDTH:0]   sumFull;
  logic             cin, cIntoMsb, cOutMsb, ovfRaw;

  function automatic logic [WIDTH-1:0] insertChunk(
    input logic [WIDTH-1:0] cur,
    input logic             first,
    input logic [WIDTH-1:0] mask,
    input logic [WIDTH-1:0] data
  );
    logic [WIDTH-1:0] base;
    base = first ? '0 : cur;
    return (base & ~mask) | (data & mask);
  endfunction

  assign strobe     = bus.rotation_event & ~prevEvt;
  assign firstChunk = (chunkQ == '0);
  assign lastChunk  = (chunkQ == IW'(CHUNKS - 1));
  assign chunkMask  = WIDTH'({NIB{1'b1}}) << (int'(chunkQ) * NIB);
  assign chunkData  = WIDTH'(bus.data_in) << (int'(chunkQ) * NIB);
  assign opNext     = (stateQ == LOAD_OP && strobe) ? 2'(bus.data_in) : opQ;

  // Every op is X + Y' + cin so carry and overflow come from one adder.
  always_comb begin
    x   = opAQ;
    y   = opBQ;
    cin = 1'b0;
    unique case (opNext)
      2'b00: begin x = opAQ; y = opBQ;  cin = 1'b0; end
      2'b01: begin x = opAQ; y = ~opBQ; cin = 1'b1; end
      2'b10: begin x = opBQ; y = ~opAQ; cin = 1'b1; end
      2'b11: begin x = '0;   y = ~opAQ; cin = 1'b1; end
    endcase
    sumFull  = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
    cOutMsb  = sumFull[WIDTH];
    cIntoMsb = x[WIDTH-1] ^ y[WIDTH-1] ^ sumFull[WIDTH-1];
    ovfRaw   = cIntoMsb ^ cOutMsb;
    sumRes   = sumFull[WIDTH-1:0];
`ifdef SATURATE_EN
    // On overflow both addends share a sign, and that sign is the true one.
    if (ovfRaw)
      sumRes = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_comb begin
    stateNext  = stateQ;
    chunkNext  = chunkQ;
    opANext    = opAQ;
    opBNext    = opBQ;
    resultNext = resultQ;
    carryNext  = carryQ;
    ovfNext    = ovfQ;
    validNext  = validQ;
    if (strobe) begin
      unique case (stateQ)
        // A strobe while showing a result is already the first A chunk.
        LOAD_A, SHOW: begin
          opANext   = insertChunk(opAQ, firstChunk, chunkMask, chunkData);
          validNext = 1'b0;
          if (lastChunk) begin
            chunkNext = '0;
            stateNext = LOAD_B;
          end else begin
            chunkNext = chunkQ + IW'(1);
            stateNext = LOAD_A;
          end
        end
        LOAD_B: begin
          opBNext = insertChunk(opBQ, firstChunk, chunkMask, chunkData);
          if (lastChunk) begin
            chunkNext = '0;
            stateNext = LOAD_OP;
          end else begin
            chunkNext = chunkQ + IW'(1);
          end
        end
        LOAD_OP: begin
          resultNext = sumRes;
          carryNext  = cOutMsb;
          ovfNext    = ovfRaw;
          validNext  = 1'b1;
          stateNext  = SHOW;
        end
      endcase
    end
  end

  // prevEvt resets high so a line already asserted at release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= LOAD_A;
      chunkQ  <= '0;
      opAQ    <= '0;
      opBQ    <= '0;
      opQ     <= '0;
      resultQ <= '0;
      carryQ  <= 1'b0;
      ovfQ    <= 1'b0;
      validQ  <= 1'b0;
      prevEvt <= 1'b1;
    end else begin
      stateQ  <= stateNext;
      chunkQ  <= chunkNext;
      opAQ    <= opANext;
      opBQ    <= opBNext;
      opQ     <= opNext;
      resultQ <= resultNext;
      carryQ  <= carryNext;
      ovfQ    <= ovfNext;
      validQ  <= validNext;
      prevEvt <= bus.rotation_event;
    end
  end

  assign bus.result    = resultQ;
  assign bus.carry_out = carryQ;
  assign bus.overflow  = ovfQ;
  assign bus.valid     = validQ;
  assign bus.state     = stateQ;

endmodule

// File: tb/tb_param_addsub_entry.sv
// Directed bench for param_addsub_entry (WIDTH=7, NIB=4) with a queue of
// expected results filled when the opcode step is keyed in.
module tb_param_addsub_entry;
  localparam int W  = 7;
  localparam int N  = 4;
  localparam int CH = (W + N - 1) / N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_addsub_entry_if #(.WIDTH(W), .NIB(N)) bus ();
  param_addsub_entry #(.WIDTH(W), .NIB(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a negedge with the line low; one strobe, then the line idles a cycle.
  task automatic applyStimulus(input logic [N-1:0] v);
    bus.data_in        = v;
    bus.rotation_event = 1'b1;
    @(negedge clk);
    bus.rotation_event = 1'b0;
    @(negedge clk);
  endtask

  // Reference arithmetic done on signed/unsigned integers, not on an adder.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int ua, ub, sa, sb, t;
    logic c;
    logic [31:0] tv;
    exp_t e;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    case (op)
      2'd0:    begin t = sa + sb; c = (ua + ub) >= (1 << W); end
      2'd1:    begin t = sa - sb; c = (ua >= ub); end
      2'd2:    begin t = sb - sa; c = (ub >= ua); end
      default: begin t = -sa;     c = (ua == 0); end
    endcase
    e.v   = (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
    tv    = t;
    e.res = tv[W-1:0];
`ifdef SATURATE_EN
    if (e.v) e.res = (t > 0) ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
`endif
    e.c = c;
    return e;
  endfunction

  task automatic waitAndCheck(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(bus.valid), 32'd1);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      checkOutput({tag, "_result"},   32'(bus.result),    32'(e.res));
      checkOutput({tag, "_carry"},    32'(bus.carry_out), 32'(e.c));
      checkOutput({tag, "_overflow"}, 32'(bus.overflow),  32'(e.v));
      checkOutput({tag, "_state"},    32'(bus.state),     32'd3);
    end
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input string tag);
    logic [31:0] av, bv;
    av = 32'(a);
    bv = 32'(b);
    for (int k = 0; k < CH; k++) applyStimulus(N'(av >> (k * N)));
    for (int k = 0; k < CH; k++) applyStimulus(N'(bv >> (k * N)));
    sbq.push_back(model(a, b, op));
    applyStimulus(N'(op));
    waitAndCheck(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    bus.rotation_event = 1'b0;
    bus.data_in        = '0;
    rst_n              = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result",   32'(bus.result),    32'd0);
    checkOutput("reset_carry",    32'(bus.carry_out), 32'd0);
    checkOutput("reset_overflow", 32'(bus.overflow),  32'd0);
    checkOutput("reset_valid",    32'(bus.valid),     32'd0);
    checkOutput("reset_state",    32'(bus.state),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Literal key sequence 5,2,A,1,0 -> 0x25 + 0x1A.
    applyStimulus(4'h5);
    applyStimulus(4'h2);
    applyStimulus(4'hA);
    applyStimulus(4'h1);
    sbq.push_back(model(7'h25, 7'h1A, 2'd0));
    applyStimulus(4'h0);
    waitAndCheck("add");
    checkOutput("add_const", 32'(bus.result), 32'h3F);

    runOp(7'h3F, 7'h01, 2'd0, "add_ovf");
`ifdef SATURATE_EN
    checkOutput("add_ovf_const", 32'(bus.result), 32'h3F);
`else
    checkOutput("add_ovf_const", 32'(bus.result), 32'h40);
`endif
    runOp(7'h05, 7'h07, 2'd1, "sub_borrow");
    checkOutput("sub_const", 32'(bus.result), 32'h7E);
    runOp(7'h05, 7'h07, 2'd2, "rsub");
    checkOutput("rsub_const", 32'(bus.result), 32'h02);
    runOp(7'h40, 7'h13, 2'd3, "neg_min");
`ifdef SATURATE_EN
    checkOutput("neg_min_const", 32'(bus.result), 32'h3F);
`else
    checkOutput("neg_min_const", 32'(bus.result), 32'h40);
`endif
    runOp(7'h00, 7'h55, 2'd3, "neg_zero");

    for (int i = 0; i < 6; i++) begin
      ra  = W'($urandom_range(0, 127));
      rb  = W'($urandom_range(0, 127));
      rop = 2'($urandom_range(0, 3));
      runOp(ra, rb, rop, "rand");
    end

    // Strobe while showing doubles as the first A chunk.
    bus.data_in        = 4'h9;
    bus.rotation_event = 1'b1;
    @(negedge clk);
    checkOutput("show_strobe_valid", 32'(bus.valid), 32'd0);
    checkOutput("show_strobe_state", 32'(bus.state), 32'd0);
    bus.rotation_event = 1'b0;
    @(negedge clk);
    applyStimulus(4'h2);
    applyStimulus(4'h3);
    applyStimulus(4'h0);
    sbq.push_back(model(7'h29, 7'h03, 2'd0));
    applyStimulus(4'h0);
    waitAndCheck("show_chain");

    // Line held high for 20 cycles captures a single chunk.
    bus.data_in        = 4'h1;
    bus.rotation_event = 1'b1;
    repeat (20) @(negedge clk);
    bus.rotation_event = 1'b0;
    @(negedge clk);
    checkOutput("hold_state", 32'(bus.state), 32'd0);
    applyStimulus(4'h3);
    checkOutput("hold_next_state", 32'(bus.state), 32'd1);
    applyStimulus(4'h2);
    applyStimulus(4'h0);
    sbq.push_back(model(7'h31, 7'h02, 2'd1));
    applyStimulus(4'h1);
    waitAndCheck("hold");

    // Abort mid-entry with the line high across reset release.
    applyStimulus(4'h7);
    applyStimulus(4'h1);
    applyStimulus(4'h5);
    bus.rotation_event = 1'b1;
    bus.data_in        = 4'hC;
    rst_n              = 1'b0;
    #1;
    checkOutput("abort_result",   32'(bus.result),    32'd0);
    checkOutput("abort_carry",    32'(bus.carry_out), 32'd0);
    checkOutput("abort_overflow", 32'(bus.overflow),  32'd0);
    checkOutput("abort_valid",    32'(bus.valid),     32'd0);
    checkOutput("abort_state",    32'(bus.state),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.rotation_event = 1'b0;
    @(negedge clk);
    checkOutput("release_high_state", 32'(bus.state), 32'd0);
    applyStimulus(4'h4);
    checkOutput("release_first_state", 32'(bus.state), 32'd0);
    applyStimulus(4'h1);
    checkOutput("release_second_state", 32'(bus.state), 32'd1);
    applyStimulus(4'h6);
    applyStimulus(4'h2);
    sbq.push_back(model(7'h14, 7'h26, 2'd2));
    applyStimulus(4'h2);
    waitAndCheck("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
